// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Sequences a programmable serial pattern matcher over parallel words. A word
//   is accepted on an in_valid/in_ready handshake and shifted MSB-first through
//   a PAT_W-bit matcher, one bit per clock. The per-word match count is
//   returned on an out_valid/out_ready port. A saturating total of all matches
//   is also kept.
//
//   Optional feature macro: SEQ_SCAN_OVERLAP_EN
//     When defined, this adds the cfg_overlap input. It is sampled on accept.
//     When the sampled value is 1, overlapping matches are counted.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   cfg_we            load cfg_pattern (only honoured in IDLE)
//   cfg_pattern       pattern, MSB is the first bit matched
//   cfg_clr           clear total_count (wins over a same-cycle hit)
//   cfg_overlap       (SEQ_SCAN_OVERLAP_EN only) count overlapping matches
//   in_valid/in_ready/in_data     word input handshake
//   out_valid/out_ready/out_count per-word result handshake
//   match_pulse       registered 1-cycle pulse per match
//   total_count       saturating count of all matches
//   busy              high while scanning or reporting
module seq_scan_ctrl #(
    parameter int               WORD_W  = 16,
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = 4'b0110
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [PAT_W-1:0]            cfg_pattern,
    input  logic                        cfg_clr,
`ifdef SEQ_SCAN_OVERLAP_EN
    input  logic                        cfg_overlap,
`endif
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(WORD_W+1)-1:0] out_count,
    output logic                        match_pulse,
    output logic [CNT_W-1:0]            total_count,
    output logic                        busy
);

    localparam int OUT_W  = $clog2(WORD_W+1);
    localparam int FILL_W = $clog2(PAT_W+1);
    localparam int BIT_W  = $clog2(WORD_W+1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_REPORT} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [OUT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic               pulse_q, pulse_d;
`ifdef SEQ_SCAN_OVERLAP_EN
    logic               overlap_q, overlap_d;
`endif

    logic               accept;
    logic               last_bit;
    logic               hit;
    logic [PAT_W-1:0]   nhist;
    logic [FILL_W-1:0]  nfill;

    assign accept   = in_valid && in_ready;
    assign last_bit = (bit_cnt_q == BIT_W'(WORD_W-1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept)    state_d = S_SHIFT;
            S_SHIFT:  if (last_bit)  state_d = S_REPORT;
            S_REPORT: if (out_ready) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Outputs. The handshake outputs and the pulse are gated by rst_n so
    // they read low for the whole reset window, not just after the first edge.
    always_comb begin
        in_ready    = rst_n && (state_q == S_IDLE);
        out_valid   = rst_n && (state_q == S_REPORT);
        busy        = rst_n && (state_q == S_SHIFT || state_q == S_REPORT);
        match_pulse = rst_n && pulse_q;
        out_count   = word_cnt_q;
        total_count = total_q;
    end

    // Matcher datapath
    always_comb begin
        pattern_d  = pattern_q;
        word_d     = word_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        pulse_d    = 1'b0;
`ifdef SEQ_SCAN_OVERLAP_EN
        overlap_d  = overlap_q;
`endif
        nhist = {hist_q[PAT_W-2:0], word_q[WORD_W-1]};
        // fill counts valid history bits since word start or last match
        nfill = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
        hit   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A pattern load in the accept cycle takes effect for that word.
                if (cfg_we) pattern_d = cfg_pattern;
                if (accept) begin
                    word_d     = in_data;
                    hist_d     = '0;
                    fill_d     = '0;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
`ifdef SEQ_SCAN_OVERLAP_EN
                    overlap_d  = cfg_overlap;
`endif
                end
            end
            S_SHIFT: begin
                hit       = (nfill == FILL_W'(PAT_W)) && (nhist == pattern_q);
                word_d    = word_q << 1;
                hist_d    = nhist;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                fill_d    = nfill;
                if (hit) begin
                    word_cnt_d = word_cnt_q + OUT_W'(1);
                    pulse_d    = 1'b1;
`ifdef SEQ_SCAN_OVERLAP_EN
                    fill_d     = overlap_q ? nfill : '0;
`else
                    fill_d     = '0;
`endif
                end
            end
            default: ;
        endcase

        // Clear wins over a same-cycle hit; the count saturates at all-ones.
        total_d = total_q;
        if (cfg_clr)                      total_d = '0;
        else if (hit && (total_q != '1))  total_d = total_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_q  <= RST_PAT;
            word_q     <= '0;
            hist_q     <= '0;
            fill_q     <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            total_q    <= '0;
            pulse_q    <= 1'b0;
`ifdef SEQ_SCAN_OVERLAP_EN
            overlap_q  <= 1'b0;
`endif
        end else begin
            pattern_q  <= pattern_d;
            word_q     <= word_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            total_q    <= total_d;
            pulse_q    <= pulse_d;
`ifdef SEQ_SCAN_OVERLAP_EN
            overlap_q  <= overlap_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Testbench for seq_scan_ctrl. Directed and random words are checked against
// a window-search reference model (count pattern occurrences in the word,
// optionally skipping ones that overlap an earlier counted match).
module tb_seq_scan_ctrl;
    localparam int WORD_W = 16;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 8;
    localparam int OUT_W  = $clog2(WORD_W+1);
`ifdef SEQ_SCAN_OVERLAP_EN
    localparam bit HAS_OVL = 1'b1;
`else
    localparam bit HAS_OVL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [PAT_W-1:0]  cfg_pattern = '0;
    logic              cfg_clr = 1'b0;
`ifdef SEQ_SCAN_OVERLAP_EN
    logic              cfg_overlap = 1'b0;
`endif
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_count;
    logic              match_pulse;
    logic [CNT_W-1:0]  total_count;
    logic              busy;

    seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W), .RST_PAT(4'b0110)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_clr(cfg_clr),
`ifdef SEQ_SCAN_OVERLAP_EN
        .cfg_overlap(cfg_overlap),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .match_pulse(match_pulse), .total_count(total_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [PAT_W-1:0] m_pat = 4'b0110;
    int m_tot = 0;

    // Count match pulses just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (match_pulse === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: slide a PAT_W window across the word MSB-first; without
    // overlap a window may only start after the end of the last counted one.
    function automatic int model(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p, input bit ovl);
        int n = 0;
        int nxt = 0;
        for (int i = 0; i <= WORD_W - PAT_W; i++) begin
            if (w[WORD_W-1-i -: PAT_W] == p && (ovl || i >= nxt)) begin
                n++;
                nxt = i + PAT_W;
            end
        end
        return n;
    endfunction

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_word(input logic [WORD_W-1:0] w, input bit ld, input logic [PAT_W-1:0] p,
                            input bit ovl, input int hold, input bit we_mid, input bit clr_last);
        int c, p0, exp_n;
        logic [OUT_W-1:0] held;
        if (ld) m_pat = p;
        exp_n = model(w, m_pat, ovl && HAS_OVL);
        chk("in_ready_idle", in_ready, 1);
        in_data = w; in_valid = 1'b1;
        cfg_we = ld; cfg_pattern = p;
`ifdef SEQ_SCAN_OVERLAP_EN
        cfg_overlap = ovl;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        p0 = pulses;
        c = 0;
        while (out_valid !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
            cfg_we = 1'b0;
            cfg_clr = 1'b0;
            if (we_mid && c == 3) begin
                chk("busy_shift", busy, 1);
                cfg_we = 1'b1; cfg_pattern = ~m_pat;
            end
            if (clr_last && c == WORD_W) cfg_clr = 1'b1;
        end
        cfg_we = 1'b0; cfg_clr = 1'b0;
        chk("latency", c, WORD_W + 1);
        held = out_count;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_count", out_count, held);
            chk("hold_in_ready", in_ready, 0);
        end
        chk("out_count", out_count, exp_n);
        chk("pulse_cnt", pulses - p0, exp_n);
        m_tot = m_tot + exp_n;
        if (m_tot > 255) m_tot = 255;
        if (clr_last) m_tot = 0;
        chk("total_count", total_count, m_tot);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        int guard;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulse", match_pulse, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_total", total_count, 0);
        chk("rst_busy_after", busy, 0);

        // Basic pattern with reset value
        run_word(16'h6666, 0, 4'h0, 0, 0, 0, 0);
        // Overlap-sensitive word
        run_word(16'h6DB0, 0, 4'h0, 0, 0, 0, 0);
        run_word(16'h6DB0, 0, 4'h0, 1, 0, 0, 0);
        // No match across a word boundary
        run_word(16'h0003, 0, 4'h0, 0, 0, 0, 0);
        run_word(16'h0000, 0, 4'h0, 0, 0, 0, 0);
        // Backpressure plus pattern write during SHIFT (ignored)
        run_word(16'h0660, 0, 4'h0, 0, 5, 1, 0);
        run_word(16'h6666, 0, 4'h0, 0, 0, 0, 0);
        // Load together with accept
        run_word(16'h9009, 1, 4'b1001, 0, 0, 0, 0);

        // Random words and patterns
        for (int i = 0; i < 20; i++)
            run_word(16'($urandom), 1, 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 0, 0);

        // Saturate total_count
        guard = 0;
        run_word(16'h6666, 1, 4'b0110, 0, 0, 0, 0);
        while (m_tot < 255 && guard < 80) begin
            run_word(16'h6666, 0, 4'h0, 0, 0, 0, 0);
            guard++;
        end
        run_word(16'h6666, 0, 4'h0, 0, 0, 0, 0);
        chk("sat_total", total_count, 255);
        // Clear coinciding with a hit on the last bit
        run_word(16'h0006, 0, 4'h0, 0, 0, 0, 1);
        run_word(16'h0006, 0, 4'h0, 0, 0, 0, 0);

        // Reset in the middle of a word
        run_word(16'h9009, 1, 4'b1001, 0, 0, 0, 0);
        in_data = 16'h6666; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_total", total_count, 0);
        m_tot = 0;
        m_pat = 4'b0110;
        run_word(16'h6666, 0, 4'h0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
